// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver.
//   DATA_W_DEFAULT : default captured bits per channel
//   SLOT_W         : nominal bclk periods per channel slot
//   state_e        : receiver framing states
package i2s_pkg;

  localparam int unsigned DATA_W_DEFAULT = 24;
  localparam int unsigned SLOT_W         = 32;

  typedef enum logic [1:0] {
    StAlign,
    StLeft,
    StRight
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer with rising-edge detection on one input.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   edge_in     : asynchronous input that is synchronized and edge-detected
//   level_in    : asynchronous inputs that are only synchronized
//   rise        : one-clk strobe on a synchronized 0->1 of edge_in
//   level_sync  : synchronized copy of level_in, aligned with the edge path
module sync_edge #(
  parameter int unsigned LEVEL_W     = 1,
  parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               edge_in,
  input  logic [LEVEL_W-1:0] level_in,
  output logic               rise,
  output logic [LEVEL_W-1:0] level_sync
);

  // All inputs travel through identical stages so that the levels sampled on a
  // rise strobe are the ones present at the source edge.
  logic [SYNC_STAGES-1:0][LEVEL_W:0] stage_q;
  logic                              edge_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      edge_prev_q <= 1'b0;
    end else begin
      stage_q     <= {stage_q[SYNC_STAGES-2:0], {level_in, edge_in}};
      edge_prev_q <= stage_q[SYNC_STAGES-1][0];
    end
  end

  assign level_sync = stage_q[SYNC_STAGES-1][LEVEL_W:1];
  assign rise       = stage_q[SYNC_STAGES-1][0] & ~edge_prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: recovers left/right samples from a codec stream and presents
// them as held frames with a valid/ready handshake.
//   clk, rst_n     : 100 MHz system clock, asynchronous active-low reset
//   enable         : 0 forces re-alignment and suppresses new frames
//   bclk_i         : codec bit clock (asynchronous, <= clk/8)
//   lrclk_i        : word select, 0 = left, 1 = right
//   sdata_i        : serial data, MSB one bclk after the lrclk change
//   out_l, out_r   : held frame
//   out_valid      : held frame available
//   out_ready      : consumer accepts the held frame
//   overrun        : sticky, a completed frame was dropped
//   clear_overrun  : single-cycle clear for overrun
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              bclk_i,
  input  logic              lrclk_i,
  input  logic              sdata_i,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              clear_overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DATA_W + 1);
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W - 1){1'b0}}};

  logic bclk_rise;
  logic lr_sync;
  logic sd_sync;

  sync_edge #(
    .LEVEL_W    (2),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .edge_in   (bclk_i),
    .level_in  ({sdata_i, lrclk_i}),
    .rise      (bclk_rise),
    .level_sync({sd_sync, lr_sync})
  );

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic              lr_prev_q;
  logic              frame_done_q;

  // Bits land at their final position (MSB first), so a short channel is
  // left-aligned with zero LSBs. Past DATA_W the mask shifts out to zero.
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] shift_ins;

  always_comb begin
    bit_mask  = MSB_MASK >> cnt_q;
    shift_ins = shift_q;
    if (sd_sync) begin
      shift_ins = shift_q | bit_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAlign;
      cnt_q        <= '0;
      shift_q      <= '0;
      left_q       <= '0;
      right_q      <= '0;
      lr_prev_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bclk_rise) begin
        lr_prev_q <= lr_sync;
      end
      if (!enable) begin
        state_q <= StAlign;
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (bclk_rise) begin
        case (state_q)
          StAlign: begin
            if (lr_prev_q && !lr_sync) begin
              state_q <= StLeft;
              cnt_q   <= '0;
              shift_q <= '0;
            end
          end
          default: begin
            if (lr_sync != lr_prev_q) begin
              // Delay bit of the next channel; its sdata is the previous LSB.
              state_q <= lr_sync ? StRight : StLeft;
              cnt_q   <= '0;
              shift_q <= '0;
              if (state_q == StLeft) begin
                left_q <= shift_q;
              end else if (cnt_q < CNT_FULL) begin
                // Short right channel: the zero-filled value completes the frame.
                right_q      <= shift_q;
                frame_done_q <= 1'b1;
              end
            end else begin
              shift_q <= shift_ins;
              if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
              end
              if (state_q == StRight && cnt_q == CNT_LAST) begin
                right_q      <= shift_ins;
                frame_done_q <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  logic frame_done;
  logic load;
  logic accept;

  assign frame_done = frame_done_q & enable;
  assign accept     = out_valid & out_ready;
  assign load       = frame_done & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_l     <= left_q;
        out_r     <= right_q;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      // A new drop wins over a simultaneous clear.
      if (frame_done && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed, table-driven bench for i2s_rx with hand-written corner sequences.
module tb_i2s_rx;
  import i2s_pkg::*;

  localparam int unsigned DW = 24;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic [DW-1:0] out_l;
  logic [DW-1:0] out_r;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          clear_overrun;

  int errors;
  int checks;
  int drop_cnt;
  logic mon_en;

  i2s_rx #(
    .DATA_W     (DW),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .bclk_i       (bclk),
    .lrclk_i      (lrclk),
    .sdata_i      (sdata),
    .out_l        (out_l),
    .out_r        (out_r),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles where out_valid dropped while monitoring is on.
  always @(negedge clk) begin
    if (!rst_n) drop_cnt <= 0;
    else if (mon_en && !out_valid) drop_cnt <= drop_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          slot;
    int          nbits;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bclk period: data changes on the falling edge; optional ready pulse
  // placed so that it covers the clk edge that loads a completed frame.
  task automatic bit_slot(input logic lr, input logic sd, input bit pulse);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    #50;
    bclk = 1'b1;
    if (pulse) begin
      #30;
      out_ready = 1'b1;
      #10;
      out_ready = 1'b0;
      #10;
    end else begin
      #50;
    end
  endtask

  // slot = bclk periods in the channel; bit 0 is the delay bit, data MSB at 1.
  task automatic send_word(input logic ch, input int slot, input int nbits,
                           input logic [31:0] w, input int pulse_k);
    while (($time % 50) != 0) @(negedge clk);
    for (int k = 0; k < slot; k++) begin
      logic sd;
      sd = 1'b0;
      if (k >= 1 && k <= nbits) sd = w[5'(nbits - k)];
      bit_slot(ch, sd, k == pulse_k);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    wait_clks(3);
    check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rst_l"}, 32'(out_l), 32'd0);
    check({tag, "_rst_r"}, 32'(out_r), 32'd0);
    check({tag, "_rst_ovr"}, 32'(overrun), 32'd0);
    rst_n = 1'b1;
    wait_clks(2);
  endtask

  task automatic accept_frame();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    mon_en        = 1'b0;
    rst_n         = 1'b0;
    enable        = 1'b1;
    bclk          = 1'b0;
    lrclk         = 1'b0;
    sdata         = 1'b0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;

    vecs[0] = '{slot: SLOT_W, nbits: 24, l: 32'hA5A5A5, r: 32'h123456,
                exp_l: 32'hA5A5A5, exp_r: 32'h123456};
    vecs[1] = '{slot: SLOT_W, nbits: 24, l: 32'hFFFFFF, r: 32'h000001,
                exp_l: 32'hFFFFFF, exp_r: 32'h000001};
    vecs[2] = '{slot: 25, nbits: 24, l: 32'h800001, r: 32'h7FFFFE,
                exp_l: 32'h800001, exp_r: 32'h7FFFFE};
    // 16-bit words: delay bit plus 16 data bits per channel.
    vecs[3] = '{slot: 17, nbits: 16, l: 32'hFFFF, r: 32'h1234,
                exp_l: 32'hFFFF00, exp_r: 32'h123400};
    vecs[4] = '{slot: SLOT_W, nbits: 20, l: 32'hABCDE, r: 32'h12345,
                exp_l: 32'hABCDE0, exp_r: 32'h123450};
    vecs[5] = '{slot: 13, nbits: 12, l: 32'h800, r: 32'hFFF,
                exp_l: 32'h800000, exp_r: 32'hFFF000};

    wait_clks(3);

    for (int i = 0; i < 6; i++) begin
      do_reset($sformatf("v%0d", i));
      // Stream joins mid-right: nothing may come out of this slot.
      send_word(1'b1, SLOT_W, 24, 32'h5A5A5A, -1);
      wait_clks(10);
      check($sformatf("v%0d_prealign_valid", i), 32'(out_valid), 32'd0);
      send_word(1'b0, vecs[i].slot, vecs[i].nbits, vecs[i].l, -1);
      send_word(1'b1, vecs[i].slot, vecs[i].nbits, vecs[i].r, -1);
      send_word(1'b0, 1, 0, 32'd0, -1);
      wait_clks(10);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_out_l", i), 32'(out_l), vecs[i].exp_l);
      check($sformatf("v%0d_out_r", i), 32'(out_r), vecs[i].exp_r);
      check($sformatf("v%0d_overrun", i), 32'(overrun), 32'd0);
      accept_frame();
      check($sformatf("v%0d_valid_after_accept", i), 32'(out_valid), 32'd0);
    end

    // Stream starting on a left slot never saw lrclk 1->0: first pair dropped.
    do_reset("noalign");
    send_word(1'b0, SLOT_W, 24, 32'h111111, -1);
    send_word(1'b1, SLOT_W, 24, 32'h222222, -1);
    wait_clks(10);
    check("noalign_first_pair_valid", 32'(out_valid), 32'd0);
    send_word(1'b0, SLOT_W, 24, 32'h333333, -1);
    send_word(1'b1, SLOT_W, 24, 32'h444444, -1);
    wait_clks(10);
    check("noalign_second_valid", 32'(out_valid), 32'd1);
    check("noalign_second_l", 32'(out_l), 32'h333333);
    check("noalign_second_r", 32'(out_r), 32'h444444);

    // Two frames without ready: first frame held, second dropped.
    do_reset("ovr");
    send_word(1'b1, SLOT_W, 24, 32'h0, -1);
    send_word(1'b0, SLOT_W, 24, 32'hA5A5A5, -1);
    send_word(1'b1, SLOT_W, 24, 32'h123456, -1);
    send_word(1'b0, SLOT_W, 24, 32'hCAFE01, -1);
    send_word(1'b1, SLOT_W, 24, 32'hBEEF02, -1);
    send_word(1'b0, 1, 0, 32'd0, -1);
    wait_clks(10);
    check("ovr_valid", 32'(out_valid), 32'd1);
    check("ovr_held_l", 32'(out_l), 32'hA5A5A5);
    check("ovr_held_r", 32'(out_r), 32'h123456);
    check("ovr_flag", 32'(overrun), 32'd1);
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    // Disabling realigns but must not disturb the held frame.
    enable = 1'b0;
    wait_clks(20);
    check("dis_valid", 32'(out_valid), 32'd1);
    check("dis_held_l", 32'(out_l), 32'hA5A5A5);
    enable = 1'b1;
    accept_frame();
    check("ovr_accepted", 32'(out_valid), 32'd0);

    // Ready coincides with the second completion: valid never drops.
    do_reset("coin");
    send_word(1'b1, SLOT_W, 24, 32'h0, -1);
    send_word(1'b0, SLOT_W, 24, 32'h0F0F0F, -1);
    send_word(1'b1, SLOT_W, 24, 32'hF0F0F0, -1);
    wait_clks(5);
    check("coin_first_valid", 32'(out_valid), 32'd1);
    mon_en = 1'b1;
    send_word(1'b0, SLOT_W, 24, 32'h654321, -1);
    send_word(1'b1, SLOT_W, 24, 32'hFEDCBA, 24);
    send_word(1'b0, 1, 0, 32'd0, -1);
    wait_clks(10);
    check("coin_valid_drops", 32'(drop_cnt), 32'd0);
    mon_en = 1'b0;
    check("coin_valid", 32'(out_valid), 32'd1);
    check("coin_second_l", 32'(out_l), 32'h654321);
    check("coin_second_r", 32'(out_r), 32'hFEDCBA);
    check("coin_overrun", 32'(overrun), 32'd0);
    accept_frame();

    // Reset mid-left with a held frame: outputs clear at once.
    do_reset("midrst");
    send_word(1'b1, SLOT_W, 24, 32'h0, -1);
    send_word(1'b0, SLOT_W, 24, 32'h777777, -1);
    send_word(1'b1, SLOT_W, 24, 32'h888888, -1);
    send_word(1'b0, 10, 10, 32'h3FF, -1);
    check("midrst_before_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_valid", 32'(out_valid), 32'd0);
    check("midrst_async_l", 32'(out_l), 32'd0);
    check("midrst_async_r", 32'(out_r), 32'd0);
    #20;
    rst_n = 1'b1;
    send_word(1'b0, 22, 0, 32'd0, -1);
    send_word(1'b1, SLOT_W, 24, 32'h999999, -1);
    wait_clks(10);
    check("midrst_partial_valid", 32'(out_valid), 32'd0);
    send_word(1'b0, SLOT_W, 24, 32'h13579B, -1);
    send_word(1'b1, SLOT_W, 24, 32'h2468AC, -1);
    wait_clks(10);
    check("midrst_next_valid", 32'(out_valid), 32'd1);
    check("midrst_next_l", 32'(out_l), 32'h13579B);
    check("midrst_next_r", 32'(out_r), 32'h2468AC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24: captured bits per channel, MSB first.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages per asynchronous input (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (100 MHz); all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: 0 forces the ALIGN state and suppresses new output.
REQ-006 SHALL have port bclk_i, input, 1 bit: codec serial clock; asynchronous to clk; at most clk/8.
REQ-007 SHALL have port lrclk_i, input, 1 bit: word select; 0 = left, 1 = right; changes on bclk falling edges.
REQ-008 SHALL have port sdata_i, input, 1 bit: ADC serial data, standard I2S timing with a 1-bclk delay.
REQ-009 SHALL have port out_l, output, DATA_W bits: left sample of the held frame.
REQ-010 SHALL have port out_r, output, DATA_W bits: right sample of the held frame.
REQ-011 SHALL have port out_valid, output, 1 bit: a held frame is available.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the frame when out_valid=1 and out_ready=1 on a clk edge.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, set when a completed frame is dropped.
REQ-014 SHALL have port clear_overrun, input, 1 bit: single-cycle pulse that clears overrun.

Function
REQ-015 SHALL synchronize bclk_i, lrclk_i and sdata_i through SYNC_STAGES flip-flops each, then detect bclk rising edges as one-clk strobes.
REQ-016 SHALL sample the synchronized lrclk and sdata only on a bclk-rise strobe.
REQ-017 SHALL use the states ALIGN, LEFT and RIGHT.
REQ-018 SHALL, in ALIGN, discard data until a sampled lrclk 1->0 transition, then enter LEFT with bit counter 0.
REQ-019 SHALL treat a sampled lrclk change as the delay bit: counter to 0, state to LEFT (0) or RIGHT (1), and that edge's sdata not captured.
REQ-020 SHALL, on subsequent strobes, shift sdata into the channel shift register while the counter runs 1..DATA_W; the counter saturates at DATA_W+1 and extra slot bits are ignored.
REQ-021 SHALL zero-fill the LSBs of a channel that ends (lrclk change) with fewer than DATA_W bits; that value stays valid data.
REQ-022 SHALL mark the frame complete in the clk cycle after the DATA_W-th right-channel bit is captured; completion occurs exactly once per right slot.
REQ-023 SHALL, on completion with out_valid=0, load out_l/out_r and set out_valid on the next edge.
REQ-024 SHALL, on completion with out_valid=1 and out_ready=1 in the same cycle, accept the old frame and load the new one, keeping out_valid=1 with no overrun.
REQ-025 SHALL, on completion with out_valid=1 and out_ready=0, keep the held frame unchanged, drop the new frame and set overrun.
REQ-026 SHALL keep out_l/out_r stable while out_valid=1; out_valid falls on acceptance when no completion occurs in the same cycle.
REQ-027 SHALL, when clear_overrun and a new overrun event coincide, leave overrun=1.
REQ-028 SHALL, on enable=0, return to ALIGN and clear the partial shift state, while leaving a held frame and out_valid intact.

Reset
REQ-029 SHALL, on rst_n=0 and asynchronously, set state=ALIGN, clear the counter, shift registers and synchronizers to 0, and set out_l=0, out_r=0, out_valid=0 and overrun=0.
REQ-030 SHALL discard any partial frame when reset is asserted mid-frame; after release, output resumes only after a fresh lrclk 1->0 alignment.

Structure
REQ-031 SHALL place DATA_W default, SLOT_W=32 and the state enum in shared package i2s_pkg.
REQ-032 SHALL implement the synchronizer plus edge detect as sub-module sync_edge, instanced for bclk; lrclk and sdata use its synchronizer-only output.

Verification
REQ-033 SHALL cover: reset release, 32-bit slots, L=0xA5A5A5 R=0x123456 -> out_valid=1 with out_l=0xA5A5A5, out_r=0x123456.
REQ-034 SHALL cover: stream started with lrclk=1 (mid-right) -> no output until after the first full left+right pair.
REQ-035 SHALL cover: out_ready=0 across two frames -> first frame held, overrun=1; clear_overrun -> overrun=0.
REQ-036 SHALL cover: out_ready=1 coincident with completion -> out_valid continuously 1, second frame presented, overrun=0.
REQ-037 SHALL cover: 16-bit slots, L=0xFFFF -> out_l=0xFFFF00.
REQ-038 SHALL cover: rst_n pulsed mid-left-slot -> all outputs 0 immediately; the next valid frame is the first complete post-reset pair.
